// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the vending transaction controller.
//   state_e  - FSM state encoding (also driven out on the state port)
//   COIN5/COIN10 - the only coin values the acceptor may credit
//   CHG_UNIT - value of one change coin ejected by the hopper
//   CREDIT_W - width of the credit register
package vend_pkg;

  localparam int CREDIT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CREDIT = 2'b01,
    S_VEND   = 2'b10,
    S_CHANGE = 2'b11
  } state_e;

  localparam logic [3:0]          COIN5    = 4'd5;
  localparam logic [3:0]          COIN10   = 4'd10;
  localparam logic [CREDIT_W-1:0] CHG_UNIT = CREDIT_W'(5);

endpackage

// File: rtl/vend_idle_timer.sv
// vend_idle_timer: counts enabled cycles since the last clear and flags
// the cycle on whose closing edge the count reaches TIMEOUT.
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   clr_i    - clear the count (takes priority over en_i)
//   en_i     - count this cycle
//   expire_o - combinational: this edge brings the count to TIMEOUT
module vend_idle_timer
  import vend_pkg::*;
#(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  assign expire_o = en_i && !clr_i && (cnt_q == W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending transaction controller. Accumulates coin credit,
// runs one dispense per purchase over a req/ack handshake and pays back
// leftover or cancelled credit as 5-unit change coins.
//   clk, rst              - clock (rising edge), async active-low reset
//   coin_valid, coin      - one-cycle coin strobe with coin value
//   sel_valid, cancel     - one-cycle purchase / refund requests
//   vend_req, vend_ack    - dispenser handshake
//   chg_req, chg_ack      - change-hopper handshake (one coin per ack)
//   coin_reject           - one-cycle pulse for a coin that was not credited
//   credit, state         - current credit and FSM state
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE      = 15,
  parameter int MAX_CREDIT = 35,
  parameter int TIMEOUT    = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [3:0]          coin,
  input  logic                sel_valid,
  input  logic                cancel,
  output logic                vend_req,
  input  logic                vend_ack,
  output logic                chg_req,
  input  logic                chg_ack,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state
);

  localparam int                  SUM_W   = CREDIT_W + 1;
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                vend_req_q, vend_req_d;
  logic                chg_req_q, chg_req_d;
  logic                coin_reject_q, coin_reject_d;

  logic [SUM_W-1:0] coin_sum;
  logic             coin_legal;
  logic             coin_ok;
  logic             tmr_clr;
  logic             tmr_expire;

  // One extra bit so the ceiling check cannot wrap.
  assign coin_sum   = {1'b0, credit_q} + SUM_W'(coin);
  assign coin_legal = (coin == COIN5) || (coin == COIN10);
  assign coin_ok    = coin_valid && coin_legal
                   && ((state_q == S_IDLE) || (state_q == S_CREDIT))
                   && (coin_sum <= SUM_W'(MAX_CREDIT))
                   && !sel_valid && !cancel;

  // Held clear outside CREDIT, so entering CREDIT always starts from zero.
  assign tmr_clr = (state_q != S_CREDIT) || coin_valid || sel_valid;

  vend_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmr_clr),
    .en_i     (1'b1),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_reject_d = coin_valid && !coin_ok;

    unique case (state_q)
      S_IDLE: begin
        if (coin_ok) begin
          credit_d = coin_sum[CREDIT_W-1:0];
          state_d  = S_CREDIT;
        end
      end
      S_CREDIT: begin
        if (cancel) begin
          state_d = S_CHANGE;
        end else if (sel_valid) begin
          if (credit_q >= PRICE_C) begin
            credit_d = credit_q - PRICE_C;
            state_d  = S_VEND;
          end
        end else if (coin_ok) begin
          credit_d = coin_sum[CREDIT_W-1:0];
        end else if (tmr_expire) begin
          state_d = S_CHANGE;
        end
      end
      S_VEND: begin
        if (vend_ack) begin
          state_d = (credit_q == '0) ? S_IDLE : S_CHANGE;
        end
      end
      S_CHANGE: begin
        if (chg_ack) begin
          credit_d = credit_q - CHG_UNIT;
          if (credit_q == CHG_UNIT) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Requests decoded from the next state so they are plain flops.
    vend_req_d = (state_d == S_VEND);
    chg_req_d  = (state_d == S_CHANGE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      vend_req_q    <= 1'b0;
      chg_req_q     <= 1'b0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      vend_req_q    <= vend_req_d;
      chg_req_q     <= chg_req_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  assign vend_req    = vend_req_q;
  assign chg_req     = chg_req_q;
  assign coin_reject = coin_reject_q;
  assign credit      = credit_q;
  assign state       = state_q;

endmodule
